proc_mem_loader: RTL and testbench



---
 rtl/proc_pkg.sv | 15 +
 rtl/mem_array.sv | 31 +++
 rtl/proc_mem_loader.sv | 134 +++++++++++++
 tb/tb_proc_mem_loader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared processor types: loader states and default bus widths
package proc_pkg;
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 8;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  typedef enum logic [1:0] {
    LOAD = ST_LOAD,
    FILL = ST_FILL,
    RUN  = ST_RUN
  } state_e;
endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - DEPTH x DATA_W storage, one clocked write port, one combinational read port
module mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  // Callers guarantee waddr < DEPTH whenever we is high.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (32'(raddr) < 32'(DEPTH)) begin
      rdata = mem[raddr[IDX_W-1:0]];
    end
  end
endmodule

// File: rtl/proc_mem_loader.sv
// rtl/proc_mem_loader.sv - program/data memory with stream image loader, tail zero-fill
// and a write-protected low region; holds the processor in reset until the image is in.
module proc_mem_loader
  import proc_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int DEPTH     = 256,
  parameter int PROT_TOP  = 0,
  parameter bit ZERO_FILL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              cpu_hold,
  output logic              load_done,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_write,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              wr_fault,
  output logic [7:0]        fault_cnt
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              hold_q, hold_d;
  logic              wr_fault_q, wr_fault_d;
  logic [7:0]        fault_cnt_q, fault_cnt_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  int                addr_i;

  assign ld_ready = !reset && (state_q == LOAD);
  assign addr_i   = 32'(mem_addr);
  assign addr_ok  = (addr_i >= PROT_TOP) && (addr_i < DEPTH);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wr_fault_d  = 1'b0;
    fault_cnt_d = fault_cnt_q;
    we          = 1'b0;
    waddr       = ptr_q;
    wdata       = ld_data;
    case (state_q)
      LOAD: begin
        if (ld_valid && ld_ready) begin
          we = 1'b1;
          if (ld_last || ptr_q == LAST) begin
            if (ZERO_FILL && ptr_q != LAST) begin
              state_d = FILL;
              ptr_d   = ptr_q + 1'b1;
            end else begin
              state_d = RUN;
            end
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      FILL: begin
        we    = 1'b1;
        wdata = '0;
        if (ptr_q == LAST) begin
          state_d = RUN;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      RUN: begin
        waddr = mem_addr;
        wdata = mem_wdata;
        if (mem_write) begin
          if (addr_ok) begin
            we = 1'b1;
          end else begin
            wr_fault_d = 1'b1;
            if (fault_cnt_q != 8'hFF) begin
              fault_cnt_d = fault_cnt_q + 8'd1;
            end
          end
        end
      end
      default: state_d = LOAD;
    endcase
    // Reset must never disturb memory contents, so the write port is gated here.
    if (reset) begin
      we = 1'b0;
    end
    hold_d = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      ptr_q       <= '0;
      hold_q      <= 1'b1;
      wr_fault_q  <= 1'b0;
      fault_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      wr_fault_q  <= wr_fault_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign cpu_hold  = reset || hold_q;
  assign load_done = !cpu_hold;
  assign wr_fault  = wr_fault_q;
  assign fault_cnt = fault_cnt_q;

  mem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(mem_addr),
    .rdata(mem_rdata)
  );
endmodule

// File: tb/tb_proc_mem_loader.sv
// tb/tb_proc_mem_loader.sv - scoreboard bench for proc_mem_loader (u0: 256 deep, PROT_TOP=16;
// u1: 200 deep, unprotected), random images and writes against a memory-image model.
module tb_proc_mem_loader;
  typedef struct { int inst; logic [7:0] d; } rd_t;
  typedef struct { int inst; bit f; logic [7:0] c; } flt_t;
  typedef struct { int inst; bit hold; bit done; bit rdy; bit flt; logic [7:0] cnt; } st_t;
  typedef struct { int inst; int cyc; } hold_t;

  logic       clk;
  logic       reset     [2];
  logic       ld_valid  [2];
  logic       ld_ready  [2];
  logic [7:0] ld_data   [2];
  logic       ld_last   [2];
  logic       cpu_hold  [2];
  logic       load_done [2];
  logic [7:0] mem_addr  [2];
  logic [7:0] mem_wdata [2];
  logic       mem_write [2];
  logic [7:0] mem_rdata [2];
  logic       wr_fault  [2];
  logic [7:0] fault_cnt [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  rd_t   rd_q[$];
  flt_t  flt_q[$];
  st_t   st_q[$];
  hold_t hold_q[$];
  bit    rd_req [2];
  bit    st_req [2];
  bit    flt_pend [2];
  bit    hold_prev [2];

  logic [7:0] model_mem [2][256];
  bit         model_run [2];
  int         model_cnt [2];

  proc_mem_loader #(.DEPTH(256), .PROT_TOP(16), .ZERO_FILL(1'b1)) u0 (
    .clk(clk), .reset(reset[0]), .ld_valid(ld_valid[0]), .ld_ready(ld_ready[0]),
    .ld_data(ld_data[0]), .ld_last(ld_last[0]), .cpu_hold(cpu_hold[0]),
    .load_done(load_done[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_write(mem_write[0]), .mem_rdata(mem_rdata[0]), .wr_fault(wr_fault[0]),
    .fault_cnt(fault_cnt[0]));

  proc_mem_loader #(.DEPTH(200), .PROT_TOP(0), .ZERO_FILL(1'b1)) u1 (
    .clk(clk), .reset(reset[1]), .ld_valid(ld_valid[1]), .ld_ready(ld_ready[1]),
    .ld_data(ld_data[1]), .ld_last(ld_last[1]), .cpu_hold(cpu_hold[1]),
    .load_done(load_done[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_write(mem_write[1]), .mem_rdata(mem_rdata[1]), .wr_fault(wr_fault[1]),
    .fault_cnt(fault_cnt[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int depth(input int i);
    return (i == 0) ? 256 : 200;
  endfunction

  function automatic int prot(input int i);
    return (i == 0) ? 16 : 0;
  endfunction

  function automatic logic [7:0] model_rd(input int i, input int a);
    return (a < depth(i)) ? model_mem[i][a] : 8'h00;
  endfunction

  // Monitor: compares whatever the DUT presents against the front of each scoreboard queue.
  rd_t m_rd;
  flt_t m_flt;
  st_t m_st;
  hold_t m_hold;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_req[i]) begin
        if (rd_q.size() == 0) chk("rd_q_underflow", 1, 0);
        else begin
          m_rd = rd_q.pop_front();
          chk("rd_inst", i, m_rd.inst);
          chk($sformatf("rdata[%0d]@%0h", i, mem_addr[i]), 32'(mem_rdata[i]), 32'(m_rd.d));
        end
      end
      if (flt_pend[i]) begin
        if (flt_q.size() == 0) chk("flt_q_underflow", 1, 0);
        else begin
          m_flt = flt_q.pop_front();
          chk("flt_inst", i, m_flt.inst);
          chk($sformatf("wr_fault[%0d]", i), 32'(wr_fault[i]), 32'(m_flt.f));
          chk($sformatf("fault_cnt[%0d]", i), 32'(fault_cnt[i]), 32'(m_flt.c));
        end
      end
      flt_pend[i] <= mem_write[i];
      if (st_req[i]) begin
        if (st_q.size() == 0) chk("st_q_underflow", 1, 0);
        else begin
          m_st = st_q.pop_front();
          chk("st_inst", i, m_st.inst);
          chk($sformatf("cpu_hold[%0d]", i), 32'(cpu_hold[i]), 32'(m_st.hold));
          chk($sformatf("load_done[%0d]", i), 32'(load_done[i]), 32'(m_st.done));
          chk($sformatf("ld_ready[%0d]", i), 32'(ld_ready[i]), 32'(m_st.rdy));
          chk($sformatf("st_wr_fault[%0d]", i), 32'(wr_fault[i]), 32'(m_st.flt));
          chk($sformatf("st_fault_cnt[%0d]", i), 32'(fault_cnt[i]), 32'(m_st.cnt));
        end
      end
      if (hold_prev[i] && !cpu_hold[i]) begin
        if (hold_q.size() == 0) chk($sformatf("unexpected_hold_fall[%0d]", i), 1, 0);
        else begin
          m_hold = hold_q.pop_front();
          chk("hold_inst", i, m_hold.inst);
          chk($sformatf("hold_fall_cycle[%0d]", i), cyc, m_hold.cyc);
        end
      end
      hold_prev[i] <= cpu_hold[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input int i, input bit hold, input bit done, input bit rdy,
                      input bit flt, input int cnt);
    st_t s;
    s.inst = i; s.hold = hold; s.done = done; s.rdy = rdy; s.flt = flt; s.cnt = 8'(cnt);
    st_q.push_back(s);
    st_req[i] = 1'b1;
    tick();
    st_req[i] = 1'b0;
  endtask

  task automatic rd(input int i, input int a);
    rd_t r;
    r.inst = i; r.d = model_rd(i, a);
    rd_q.push_back(r);
    mem_addr[i] = 8'(a);
    rd_req[i] = 1'b1;
    tick();
    rd_req[i] = 1'b0;
  endtask

  // Processor write; the same cycle also checks that the read path still shows the old word.
  task automatic wr(input int i, input int a, input logic [7:0] d);
    rd_t r;
    flt_t f;
    mem_addr[i] = 8'(a); mem_wdata[i] = d; mem_write[i] = 1'b1;
    if (model_run[i]) begin
      r.inst = i; r.d = model_rd(i, a);
      rd_q.push_back(r);
      rd_req[i] = 1'b1;
    end
    f.inst = i; f.f = 1'b0;
    if (model_run[i]) begin
      if (a < prot(i) || a >= depth(i)) begin
        f.f = 1'b1;
        if (model_cnt[i] < 255) model_cnt[i]++;
      end else begin
        model_mem[i][a] = d;
      end
    end
    f.c = 8'(model_cnt[i]);
    flt_q.push_back(f);
    tick();
    mem_write[i] = 1'b0; rd_req[i] = 1'b0;
  endtask

  task automatic reset_pulse(input int i);
    reset[i] = 1'b1;
    tick();
    model_run[i] = 1'b0;
    model_cnt[i] = 0;
    snap(i, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    reset[i] = 1'b0;
    snap(i, 1'b1, 1'b0, 1'b1, 1'b0, 0);
  endtask

  // Streams img; optional bubble of nbub idle cycles before word bub_at. k0 = cycle word 0 is taken.
  task automatic load_img(input int i, input logic [7:0] img[$], input bit last,
                          input int bub_at, input int nbub, output int k0);
    int t;
    k0 = -1;
    for (int k = 0; k < img.size(); k++) begin
      if (k == bub_at) begin
        ld_valid[i] = 1'b0;
        repeat (nbub) @(posedge clk);
        #1;
      end
      ld_valid[i] = 1'b1;
      ld_data[i]  = img[k];
      ld_last[i]  = last && (k == img.size() - 1);
      @(negedge clk);
      t = 0;
      while (!ld_ready[i] && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("ld_ready_wait[%0d]", i), 32'(ld_ready[i]), 1);
      if (k == 0) k0 = cyc;
      tick();
    end
    ld_valid[i] = 1'b0;
    ld_last[i]  = 1'b0;
    foreach (img[k]) model_mem[i][k] = img[k];
    if (last || img.size() == depth(i)) begin
      for (int a = img.size(); a < depth(i); a++) model_mem[i][a] = 8'h00;
      model_run[i] = 1'b1;
    end
  endtask

  task automatic expect_fall(input int i, input int at);
    hold_t h;
    h.inst = i; h.cyc = at;
    hold_q.push_back(h);
  endtask

  task automatic wait_run(input int i);
    int t = 0;
    while (!load_done[i] && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("load_done_wait[%0d]", i), 32'(load_done[i]), 1);
    tick();
  endtask

  logic [7:0] img[$];
  int k0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1; ld_valid[i] = 1'b0; ld_data[i] = '0; ld_last[i] = 1'b0;
      mem_addr[i] = '0; mem_wdata[i] = '0; mem_write[i] = 1'b0;
      rd_req[i] = 1'b0; st_req[i] = 1'b0; flt_pend[i] = 1'b0; hold_prev[i] = 1'b1;
      model_run[i] = 1'b0; model_cnt[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    snap(0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    snap(1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    reset[0] = 1'b0; reset[1] = 1'b0;
    snap(0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    snap(1, 1'b1, 1'b0, 1'b1, 1'b0, 0);

    // Processor write while held: ignored, no fault.
    wr(0, 8'h20, 8'h77);

    // Short image, zero-filled tail; hold released 256 cycles after the first word.
    img = '{8'hA1, 8'hB2, 8'hC3};
    load_img(0, img, 1'b1, -1, 0, k0);
    expect_fall(0, k0 + 256);
    wait_run(0);
    snap(0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    for (int a = 0; a < 256; a++) rd(0, a);

    // Protected region boundary, then random writes across the whole address space.
    wr(0, 8'h0F, 8'h55);
    rd(0, 8'h0F);
    wr(0, 8'h10, 8'h55);
    rd(0, 8'h10);
    for (int n = 0; n < 40; n++) wr(0, int'($urandom_range(0, 255)), 8'($urandom));
    wr(0, 8'h40, 8'h12);
    wr(0, 8'h40, 8'h34);
    for (int a = 0; a < 256; a++) rd(0, a);

    // Reset part-way through a 10-word load, then reload.
    reset_pulse(0);
    img = {};
    for (int k = 0; k < 5; k++) img.push_back(8'($urandom));
    load_img(0, img, 1'b0, -1, 0, k0);
    reset_pulse(0);
    img = {};
    for (int k = 0; k < 10; k++) img.push_back(8'(8'h11 + k));
    load_img(0, img, 1'b1, -1, 0, k0);
    expect_fall(0, k0 + 256);
    wait_run(0);
    for (int a = 0; a < 16; a++) rd(0, a);

    // Full-depth image without ld_last goes straight to RUN; later load words are dropped.
    reset_pulse(0);
    img = {};
    for (int k = 0; k < 256; k++) img.push_back(8'($urandom));
    load_img(0, img, 1'b0, -1, 0, k0);
    expect_fall(0, k0 + 256);
    wait_run(0);
    ld_valid[0] = 1'b1; ld_data[0] = 8'hEE;
    snap(0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    repeat (4) tick();
    ld_valid[0] = 1'b0;
    for (int a = 0; a < 256; a++) rd(0, a);

    // Shallow instance: bubbles mid-image, out-of-range reads/writes, counter saturation.
    img = {};
    for (int k = 0; k < 10; k++) img.push_back(8'($urandom));
    load_img(1, img, 1'b1, 4, 3, k0);
    expect_fall(1, k0 + 200 + 3);
    wait_run(1);
    for (int a = 0; a < 200; a++) rd(1, a);
    rd(1, 250);
    rd(1, 255);
    wr(1, 250, 8'hAB);
    rd(1, 250);
    for (int n = 0; n < 300; n++) wr(1, int'($urandom_range(200, 255)), 8'($urandom));
    tick();
    snap(1, 1'b0, 1'b1, 1'b0, 1'b0, 255);
    wr(1, 7, 8'h5A);
    rd(1, 7);

    repeat (3) tick();
    chk("rd_q_left", rd_q.size(), 0);
    chk("flt_q_left", flt_q.size(), 0);
    chk("st_q_left", st_q.size(), 0);
    chk("hold_q_left", hold_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
